sine_pipe_scheduler: RTL and testbench
======================================

// Module: sine_pipe_scheduler
// PURPOSE
//  Shares one sine_approx pipeline (y = x - x^3/6, S3.4, latency 5) among NUM_REQ QFT phase-rotation requesters.
//  Round-robin arbitration issues at most one angle per cycle; a tag pipeline aligned to the datapath returns
//  each result to its owner with requester ID. Per-requester outstanding limit, issue counter, busy/idle status.
// PARAMETERS
//  NUM_REQ    4  number of requesters (2..8)
//  ID_W       2  requester ID width, = clog2(NUM_REQ)
//  MAX_OUTST  2  max in-flight ops per requester (1..5)
//  SIN_LAT    5  sine_approx latency in cycles; fixed, checked at elaboration
//  CNT_W      16 issue-counter width
// PORTS
//  clk        in   1                     system clock, rising edge
//  rst_n      in   1                     asynchronous active-low reset
//  req_valid  in   NUM_REQ               per-requester request strobe
//  req_ready  out  NUM_REQ               per-requester accept (grant), one-hot or zero
//  req_angle  in   NUM_REQ*TOTAL_WIDTH   packed angles, S3.4, slot i = bits [i*TW +: TW]
//  resp_valid out  1                     result valid this cycle
//  resp_id    out  ID_W                  owner of result
//  resp_data  out  TOTAL_WIDTH           sin(angle), S3.4
//  busy       out  1                     any op in flight
//  issue_cnt  out  CNT_W                 total accepted ops, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: req_ready=0, resp_valid=0, resp_id=0, resp_data=0, busy=0, issue_cnt=0; tag pipe, outstanding counters and
//   RR pointer (=0) cleared. Reset mid-operation drops all in-flight ops; no response is ever produced for them.
//  Eligibility: req i eligible iff req_valid[i] && outst[i] < MAX_OUTST.
//  Arbitration (combinational from registered RR pointer): grant the first eligible index at or after ptr, wrapping
//   modulo NUM_REQ. req_ready = one-hot grant; zero if nothing eligible. req_ready may depend on req_valid.
//  On accept (req_valid[g]&&req_ready[g]): ptr <= (g+1) mod NUM_REQ; issue_cnt++; outst[g]++. No accept: ptr holds.
//  Datapath: sine_approx.x = granted angle, else 0 (datapath runs freely; idle slots are carried untagged).
//  Tag pipe: SIN_LAT stages of {vld, id}; stage0 <= {accept, g} every cycle.
//  Latency: op accepted in cycle k -> resp_valid=1, resp_id=g, resp_data=y in cycle k+5 exactly.
//   resp_data = sine_approx.y passed straight through; resp_valid/resp_id = last tag stage.
//  No response back-pressure: requesters must sink resp every cycle; a response is presented for exactly one cycle.
//  Outstanding: outst[resp_id]-- on resp_valid; an accept and a response for the same id in one cycle leave it unchanged.
//   Counter never exceeds MAX_OUTST nor goes below 0.
//  Throughput: 1 op/cycle sustained with >=2 active requesters; a single requester is limited to MAX_OUTST per 5 cycles.
//  busy = OR of tag-pipe vld bits (registered); busy=0 implies all outst counters are 0.
//  Arithmetic: resp_data inherits the sine_approx truncation (arithmetic >>>15, floor); no saturation here;
//   input angle range is the caller's responsibility (|x| <= ~2.0 for accuracy).
// STRUCTURE
//  Shared header (shared_header.vh): TOTAL_WIDTH, MULT_WIDTH; add SIN_LAT_CYCLES=5 and ID width macro so the
//   pipeline latency and the scheduler stay in lockstep.
//  Sub-module: rr_arbiter (NUM_REQ-wide round-robin, ptr in, one-hot grant + encoded id out); sine_approx instanced
//   unchanged. Tag pipe, outstanding counters and issue counter are local.
// TESTING
//  Reset then single req0 angle 16 (1.0) at cycle k -> cycle k+5: resp_valid=1, id=0, data=14; busy=0 by k+6.
//  All 4 reqs valid continuously, angles 8/16/-16/32 -> grants 0,1,2,3,0...; responses data 8,14,-13,11 with ids
//   0,1,2,3, one per cycle, each at its issue cycle +5.
//  req1 alone held valid, MAX_OUTST=2 -> 2 accepts on back-to-back cycles, ready low 3 cycles, then re-granted in the
//   same cycle its first response returns (simultaneous inc/dec; outst stays 2).
//  rst_n pulled low with 3 ops in flight -> outputs zero immediately (async); after release no stray resp_valid.
//  Fairness: req0 and req2 always valid, req1 toggling -> no requester starved > NUM_REQ-1 cycles; issue_cnt equals
//   accept count, wraps at 2^CNT_W (force CNT_W=4 run: 16 accepts -> 0).
//  Random valid stimulus vs scoreboard model: every accept has exactly one response, in order per id, at +5 cycles.

Source files
------------

// File: rtl/sine_pipe_scheduler_pkg.sv
// Shared fixed-point formats and pipeline constants for the sine scheduler and its datapath.
// Keeps the sine_approx latency and the scheduler's tag pipe in lockstep.
package sine_pipe_scheduler_pkg;

    localparam int TOTAL_WIDTH    = 8;   // S3.4
    localparam int FRAC_WIDTH     = 4;
    localparam int MULT_WIDTH     = 32;
    localparam int SIN_LAT_CYCLES = 5;

    // 1/6 as Q7 (21/128); the cube is Q12, so >>>15 lands the product back in Q4.
    localparam int INV6_Q7    = 21;
    localparam int INV6_SHIFT = 15;

    typedef logic signed [TOTAL_WIDTH-1:0] angle_t;
    typedef logic signed [MULT_WIDTH-1:0]  wide_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping modulo N.
// Zero latency; grant is zero when no request is raised.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic           gnt_vld_o
);

    int idx;

    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr_i) + off) % N;
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o  = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/sine_approx.sv
// Pipelined y = x - x^3/6 in S3.4, arithmetic-shift (floor) truncation, no saturation.
// Fixed SIN_LAT_CYCLES latency, accepts a new x every cycle, no backpressure.
module sine_approx
    import sine_pipe_scheduler_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  angle_t x_i,
    output angle_t y_o
);

    angle_t x1_q, x2_q, x3_q, x4_q;
    wide_t  sq_q, cube_q;
    wide_t  term_d;
    angle_t term_q;
    angle_t y_q;

    always_comb begin
        term_d = (cube_q * wide_t'(INV6_Q7)) >>> INV6_SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q   <= '0;
            x2_q   <= '0;
            x3_q   <= '0;
            x4_q   <= '0;
            sq_q   <= '0;
            cube_q <= '0;
            term_q <= '0;
            y_q    <= '0;
        end else begin
            x1_q   <= x_i;
            sq_q   <= wide_t'(x1_q) * wide_t'(x1_q);
            x2_q   <= x1_q;
            cube_q <= sq_q * wide_t'(x2_q);
            x3_q   <= x2_q;
            term_q <= angle_t'(term_d);
            x4_q   <= x3_q;
            y_q    <= x4_q - term_q;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/sine_pipe_scheduler.sv
// Time-shares one sine_approx pipeline among NUM_REQ requesters; round-robin, one issue per cycle.
// Results return exactly SIN_LAT cycles after accept; requesters stall only at their outstanding limit.
module sine_pipe_scheduler
    import sine_pipe_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int MAX_OUTST = 2,
    parameter int SIN_LAT   = SIN_LAT_CYCLES,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*TOTAL_WIDTH-1:0] req_angle_i,
    output logic                           resp_valid_o,
    output logic [ID_W-1:0]                resp_id_o,
    output logic [TOTAL_WIDTH-1:0]         resp_data_o,
    output logic                           busy_o,
    output logic [CNT_W-1:0]               issue_cnt_o
);

    localparam int               OUT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [OUT_W-1:0] MAX_O   = OUT_W'(MAX_OUTST);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    if (SIN_LAT != SIN_LAT_CYCLES) begin : g_bad_lat
        $error("sine_pipe_scheduler: SIN_LAT does not match the sine_approx latency");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ)) begin : g_bad_req
        $error("sine_pipe_scheduler: NUM_REQ must be 2..8 with ID_W = clog2(NUM_REQ)");
    end
    if (MAX_OUTST < 1 || MAX_OUTST > 5) begin : g_bad_outst
        $error("sine_pipe_scheduler: MAX_OUTST must be 1..5");
    end

    logic                 run_q;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_W-1:0]     outst_q [NUM_REQ];
    logic [OUT_W-1:0]     outst_d [NUM_REQ];
    tag_t                 tag_q   [SIN_LAT];
    tag_t                 tag_d;
    logic [NUM_REQ-1:0]   elig, gnt, ret_hit, inc;
    logic [ID_W-1:0]      gnt_id;
    logic                 gnt_vld;
    angle_t               sin_x, sin_y;

    // A returning op frees its slot in the same cycle, so a full requester is re-granted immediately.
    always_comb begin
        ret_hit = '0;
        elig    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ret_hit[i] = tag_q[SIN_LAT-1].vld && (tag_q[SIN_LAT-1].id == ID_W'(i));
            elig[i]    = run_q && req_valid_i[i] && ((outst_q[i] < MAX_O) || ret_hit[i]);
        end
    end

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_arb (
        .req_i     (elig),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        sin_x     = '0;
        tag_d.vld = gnt_vld;
        tag_d.id  = '0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        if (gnt_vld) begin
            sin_x    = req_angle_i[gnt_id*TOTAL_WIDTH +: TOTAL_WIDTH];
            tag_d.id = gnt_id;
            ptr_d    = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        inc = gnt;
        for (int i = 0; i < NUM_REQ; i++) begin
            outst_d[i] = outst_q[i];
            if (inc[i] && !ret_hit[i]) begin
                outst_d[i] = outst_q[i] + OUT_W'(1);
            end else if (ret_hit[i] && !inc[i]) begin
                outst_d[i] = outst_q[i] - OUT_W'(1);
            end
        end
    end

    sine_approx u_sine (
        .clk   (clk),
        .rst_n (rst_n),
        .x_i   (sin_x),
        .y_o   (sin_y)
    );

    // run_q keeps req_ready low while reset is asserted even if req_valid is already high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= '0;
            end
            for (int s = 0; s < SIN_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            run_q <= 1'b1;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
            tag_q[0] <= tag_d;
            for (int s = 1; s < SIN_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int s = 0; s < SIN_LAT; s++) begin
            busy_o = busy_o | tag_q[s].vld;
        end
    end

    assign req_ready_o  = gnt;
    assign resp_valid_o = tag_q[SIN_LAT-1].vld;
    assign resp_id_o    = tag_q[SIN_LAT-1].id;
    assign resp_data_o  = sin_y;
    assign issue_cnt_o  = cnt_q;

endmodule

// File: tb/tb_sine_pipe_scheduler.sv
// Scoreboard bench: accepts push expected {cycle, id, sin} entries, responses pop and compare.
// A second instance with a 4-bit issue counter covers counter wrap under the same stimulus.
module tb_sine_pipe_scheduler;

    localparam int NR  = 4;
    localparam int MAX = 2;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_angle = '0;
    logic [3:0]  req_ready, ready4;
    logic        resp_valid, resp_valid4;
    logic [1:0]  resp_id, resp_id4;
    logic [7:0]  resp_data, resp_data4;
    logic        busy, busy4;
    logic [15:0] issue_cnt;
    logic [3:0]  issue_cnt4;

    sine_pipe_scheduler #(.NUM_REQ(NR), .MAX_OUTST(MAX), .CNT_W(16)) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid_i (req_valid), .req_ready_o (req_ready), .req_angle_i (req_angle),
        .resp_valid_o (resp_valid), .resp_id_o (resp_id), .resp_data_o (resp_data),
        .busy_o (busy), .issue_cnt_o (issue_cnt)
    );

    sine_pipe_scheduler #(.NUM_REQ(NR), .MAX_OUTST(MAX), .CNT_W(4)) dut_c4 (
        .clk (clk), .rst_n (rst_n),
        .req_valid_i (req_valid), .req_ready_o (ready4), .req_angle_i (req_angle),
        .resp_valid_o (resp_valid4), .resp_id_o (resp_id4), .resp_data_o (resp_data4),
        .busy_o (busy4), .issue_cnt_o (issue_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 due;
        int                 id;
        logic signed [7:0]  data;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;
    logic fair_en = 1'b0;
    int   m_ptr = 0;
    int   m_outst[4];
    int   acc_cnt = 0;
    int   wait_c[4];
    int   max_wait = 0;
    int   t2_exp[4] = '{8, 14, -13, 11};

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic signed [7:0] sin_ref(input int x);
        return 8'(x - ((x * x * x * 21) >>> 15));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model, evaluated mid-cycle while inputs and outputs are stable.
    logic       ret, exp_busy;
    exp_t       e;
    logic [3:0] exp_g, elig_m;
    always @(negedge clk) begin
        if (mon_en) begin
            ret = 1'b0;
            e.due = 0; e.id = 0; e.data = 0;
            exp_busy = (sb_q.size() > 0);
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                ret = 1'b1;
                e = sb_q.pop_front();
            end
            check_eq("busy", busy, exp_busy);
            check_eq("issue_cnt", issue_cnt, acc_cnt & 32'hFFFF);
            check_eq("issue_cnt_w4", issue_cnt4, acc_cnt & 32'hF);
            check_eq("resp_valid", resp_valid, ret);
            check_eq("resp_valid_w4", resp_valid4, ret);
            if (ret) begin
                check_eq("resp_id", resp_id, e.id);
                check_eq("resp_data", $signed(resp_data), e.data);
            end
            for (int i = 0; i < 4; i++) begin
                elig_m[i] = req_valid[i] && ((m_outst[i] - ((ret && e.id == i) ? 1 : 0)) < MAX);
            end
            exp_g = '0;
            for (int off = 0; off < 4; off++) begin
                int idx;
                idx = (m_ptr + off) % 4;
                if (exp_g == 0 && elig_m[idx]) exp_g[idx] = 1'b1;
            end
            check_eq("req_ready", req_ready, exp_g);
            check_eq("req_ready_w4", ready4, exp_g);
            if (fair_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (elig_m[i] && !req_ready[i]) begin
                        wait_c[i]++;
                        if (wait_c[i] > max_wait) max_wait = wait_c[i];
                    end else begin
                        wait_c[i] = 0;
                    end
                end
            end
            if (ret) m_outst[e.id]--;
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    m_outst[i]++;
                    m_ptr = (i + 1) % 4;
                    acc_cnt++;
                    sb_q.push_back('{cyc + LAT, i, sin_ref($signed(req_angle[i*8 +: 8]))});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_angle(input int slot, input int a);
        req_angle[slot*8 +: 8] = 8'(a);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then restarts the model.
    task automatic apply_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_id", resp_id, 0);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_issue_cnt", issue_cnt, 0);
        check_eq("rst_issue_cnt_w4", issue_cnt4, 0);
        sb_q.delete();
        m_ptr   = 0;
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) m_outst[i] = 0;
        repeat (2) @(posedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_outst[i] = 0;
            wait_c[i]  = 0;
        end
        req_valid = 4'hF;
        #3;
        apply_reset();

        // Single request: angle 1.0 -> 14 after exactly five cycles.
        set_angle(0, 16);
        req_valid = 4'b0001;
        @(negedge clk);
        check_eq("t1_ready", req_ready, 1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            @(negedge clk);
            if (c < 5) check_eq("t1_early_valid", resp_valid, 0);
            if (c == 5) begin
                check_eq("t1_valid", resp_valid, 1);
                check_eq("t1_id", resp_id, 0);
                check_eq("t1_data", $signed(resp_data), 14);
            end
            if (c == 6) check_eq("t1_busy_clear", busy, 0);
        end

        // All four requesters continuously valid: strict rotation, one result per cycle.
        apply_reset();
        set_angle(0, 8);
        set_angle(1, 16);
        set_angle(2, -16);
        set_angle(3, 32);
        req_valid = 4'hF;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c < 8) check_eq("t2_grant", req_ready, 1 << (c % 4));
            if (c >= 5) begin
                check_eq("t2_valid", resp_valid, 1);
                check_eq("t2_id", resp_id, (c - 5) % 4);
                check_eq("t2_data", $signed(resp_data), t2_exp[(c - 5) % 4]);
            end
            tick();
            if (c == 7) req_valid = '0;
        end
        repeat (3) tick();

        // Lone requester hits its outstanding limit and is re-granted as its first result returns.
        set_angle(1, 20);
        req_valid = 4'b0010;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_eq("t3_ready", req_ready[1], (c % 5) < 2);
            tick();
            if (c == 11) req_valid = '0;
        end
        repeat (6) tick();

        // Reset with three operations in flight: outputs clear at once, nothing stray afterwards.
        req_valid = 4'hF;
        repeat (2) tick();
        @(posedge clk);
        #3;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("t4_no_stray", resp_valid, 0);
            tick();
        end

        // Fairness: req0/req2 always valid, req1 toggling.
        for (int i = 0; i < 4; i++) wait_c[i] = 0;
        max_wait = 0;
        fair_en  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < 4; i++) set_angle(i, int'($urandom_range(0, 64)) - 32);
            req_valid = {1'b0, 1'b1, 1'(c & 1), 1'b1};
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        fair_en = 1'b0;
        check_eq("fair_no_starve", max_wait <= NR - 1, 1);
        repeat (6) tick();

        // Random traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) set_angle(i, int'($urandom_range(0, 64)) - 32);
            req_valid = 4'($urandom_range(0, 15));
            tick();
        end
        req_valid = '0;
        repeat (8) tick();
        @(negedge clk);
        check_eq("drain_empty", sb_q.size(), 0);
        check_eq("drain_busy", busy, 0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
